// File: rtl/time_set_ctl_pkg.sv
// Shared types and constants for the time-set controller slice.
package time_set_ctl_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_YEAR  = 3'd1,
        ST_MONTH = 3'd2,
        ST_DAY   = 3'd3,
        ST_HOUR  = 3'd4,
        ST_MIN   = 3'd5
    } state_t;

    localparam logic [3:0] MODE_MS  = 4'b0000;
    localparam logic [3:0] MODE_H24 = 4'b0001;
    localparam logic [3:0] MODE_H12 = 4'b0011;
    localparam logic [3:0] MODE_MD  = 4'b0111;
    localparam logic [3:0] MODE_Y   = 4'b1111;

    localparam logic [2:0] FIELD_NONE  = 3'd0;
    localparam logic [2:0] FIELD_YEAR  = 3'd1;
    localparam logic [2:0] FIELD_MONTH = 3'd2;
    localparam logic [2:0] FIELD_DAY   = 3'd3;
    localparam logic [2:0] FIELD_HOUR  = 3'd4;
    localparam logic [2:0] FIELD_MIN   = 3'd5;

    // View-mode cycle order used by the mode button in RUN.
    function automatic logic [3:0] next_mode(input logic [3:0] cur);
        logic [3:0] nxt;
        nxt = MODE_MS;
        case (cur)
            MODE_MS:  nxt = MODE_H24;
            MODE_H24: nxt = MODE_H12;
            MODE_H12: nxt = MODE_MD;
            MODE_MD:  nxt = MODE_Y;
            default:  nxt = MODE_MS;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/time_set_ctl_if.sv
// Button/timebase inputs and display/counter-control outputs of the controller.
interface time_set_ctl_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_set;
    logic       btn_inc;
    logic [3:0] mode;
    logic       run_en;
    logic [2:0] field_sel;
    logic       inc_pulse;
    logic       sec_clr;
    logic       blink;

    modport master (
        output tick, btn_mode, btn_set, btn_inc,
        input  mode, run_en, field_sel, inc_pulse, sec_clr, blink
    );

    modport slave (
        input  tick, btn_mode, btn_set, btn_inc,
        output mode, run_en, field_sel, inc_pulse, sec_clr, blink
    );
endinterface

// File: rtl/time_set_ctl_btn_rpt.sv
// Rising-edge detect plus hold-to-auto-repeat for one debounced button.
// fire is a combinational event: the press itself, the first repeat after
// HOLD_TICKS held ticks, then one every RPT_TICKS ticks. clr suppresses fire
// and restarts the hold timing.
module btn_rpt #(
    parameter int unsigned HOLD_TICKS = 50,
    parameter int unsigned RPT_TICKS  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    input  logic clr,
    output logic press,
    output logic fire
);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam int unsigned RW = $clog2(RPT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_TICKS - 1);

    logic          btn_q;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rpt_cnt;
    logic          holding;
    logic          hold_hit;
    logic          rpt_hit;

    assign press    = btn & ~btn_q;
    assign holding  = btn & ~press & ~clr;
    assign hold_hit = holding & tick & (hold_cnt == HOLD_LAST);
    assign rpt_hit  = holding & tick & (hold_cnt == HOLD_MAX) & (rpt_cnt == RPT_LAST);
    assign fire     = ~clr & (press | hold_hit | rpt_hit);

    // Button history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

    // Hold counter saturates at HOLD_TICKS, then the repeat counter takes over.
    always_ff @(posedge clk) begin
        if (rst || !holding) begin
            hold_cnt <= '0;
            rpt_cnt  <= '0;
        end else if (tick) begin
            if (hold_cnt != HOLD_MAX)     hold_cnt <= hold_cnt + 1'b1;
            else if (rpt_cnt == RPT_LAST) rpt_cnt  <= '0;
            else                          rpt_cnt  <= rpt_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/time_set_ctl.sv
// Sequencing controller: view-mode selection, run gating and the
// year/month/day/hour/minute set sequence with auto-repeat and blink.
module time_set_ctl
    import time_set_ctl_pkg::*;
#(
    parameter int unsigned HOLD_TICKS    = 50,
    parameter int unsigned RPT_TICKS     = 10,
    parameter int unsigned BLINK_TICKS   = 25,
    parameter int unsigned TIMEOUT_TICKS = 1000
) (
    input  logic           clk,
    input  logic           rst,
    time_set_ctl_if.slave  bus
);
    localparam int unsigned IW = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_TICKS);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    state_t        state, state_next;
    logic [3:0]    run_mode;
    logic [3:0]    mode_out;
    logic [2:0]    field_out;
    logic          run_out;
    logic          mode_btn_q, set_btn_q;
    logic          press_mode, press_set;
    logic          inc_press, inc_fire, rpt_clr;
    logic          idle_busy, timeout;
    logic [IW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_q, inc_q, sec_q;

    assign press_mode = bus.btn_mode & ~mode_btn_q;
    assign press_set  = bus.btn_set & ~set_btn_q;

    // Repeat timing is held cleared in RUN and on any set press, so a set
    // press always wins over a coincident increment.
    assign rpt_clr = press_set | (state == ST_RUN);

    btn_rpt #(
        .HOLD_TICKS (HOLD_TICKS),
        .RPT_TICKS  (RPT_TICKS)
    ) u_inc_rpt (
        .clk   (clk),
        .rst   (rst),
        .tick  (bus.tick),
        .btn   (bus.btn_inc),
        .clr   (rpt_clr),
        .press (inc_press),
        .fire  (inc_fire)
    );

    assign idle_busy = press_mode | press_set | inc_press | bus.btn_inc;
    assign timeout   = (state != ST_RUN) & ~idle_busy & bus.tick & (idle_cnt == IDLE_LAST);

    // Mode and set button history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_btn_q <= 1'b0;
            set_btn_q  <= 1'b0;
        end else begin
            mode_btn_q <= bus.btn_mode;
            set_btn_q  <= bus.btn_set;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // Next-state and per-state display/run outputs.
    always_comb begin
        state_next = state;
        mode_out   = run_mode;
        field_out  = FIELD_NONE;
        run_out    = 1'b0;
        unique case (state)
            ST_RUN: begin
                run_out = 1'b1;
                if (press_set) state_next = ST_YEAR;
            end
            ST_YEAR: begin
                mode_out  = MODE_Y;
                field_out = FIELD_YEAR;
                if (press_set)    state_next = ST_MONTH;
                else if (timeout) state_next = ST_RUN;
            end
            ST_MONTH: begin
                mode_out  = MODE_MD;
                field_out = FIELD_MONTH;
                if (press_set)    state_next = ST_DAY;
                else if (timeout) state_next = ST_RUN;
            end
            ST_DAY: begin
                mode_out  = MODE_MD;
                field_out = FIELD_DAY;
                if (press_set)    state_next = ST_HOUR;
                else if (timeout) state_next = ST_RUN;
            end
            ST_HOUR: begin
                mode_out  = MODE_H24;
                field_out = FIELD_HOUR;
                if (press_set)    state_next = ST_MIN;
                else if (timeout) state_next = ST_RUN;
            end
            ST_MIN: begin
                mode_out  = MODE_MS;
                field_out = FIELD_MIN;
                if (press_set || timeout) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // RUN view mode; held untouched through the set sequence.
    always_ff @(posedge clk) begin
        if (rst)
            run_mode <= MODE_MS;
        else if (state == ST_RUN && press_mode && !press_set)
            run_mode <= next_mode(run_mode);
    end

    // Registered single-cycle increment and seconds-clear pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_q <= 1'b0;
            sec_q <= 1'b0;
        end else begin
            inc_q <= inc_fire;
            sec_q <= (state == ST_MIN) & press_set;
        end
    end

    // Idle-tick counter that drives the set-state timeout.
    always_ff @(posedge clk) begin
        if (rst || state == ST_RUN || state_next != state)
            idle_cnt <= '0;
        else if (idle_busy)
            idle_cnt <= '0;
        else if (bus.tick && idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;
    end

    // Blink: on at each set-state entry, toggled every BLINK_TICKS ticks, off in RUN.
    always_ff @(posedge clk) begin
        if (rst || state_next == ST_RUN) begin
            blink_q   <= 1'b0;
            blink_cnt <= '0;
        end else if (state_next != state) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
        end else if (bus.tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign bus.mode      = mode_out;
    assign bus.field_sel = field_out;
    assign bus.run_en    = run_out;
    assign bus.inc_pulse = inc_q;
    assign bus.sec_clr   = sec_q;
    assign bus.blink     = blink_q;

endmodule
